// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C bus master.
// Runs one START / address+R/W / ACK / data byte / ACK / STOP sequence per
// accepted command and reports the read byte and any slave NACK.
// SDA is open-drain: sda_oe=1 pulls the line low, 0 releases it.
module i2c_master #(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   input  logic [6:0] cmd_addr,
   input  logic       cmd_rw,
   input  logic [7:0] cmd_wdata,
   input  logic       sda_in,
   output logic       scl,
   output logic       sda_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic [7:0] rdata
);

   localparam int QW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      IDLE, START, ADDR, ADDR_ACK, WDATA, RDATA, DATA_ACK, STOP
   } state_t;

   state_t        r_state, w_next;
   logic [QW-1:0] r_qcnt;
   logic [1:0]    r_q;
   logic [2:0]    r_bit;
   logic [7:0]    r_addrByte;
   logic [7:0]    r_wdata;
   logic [7:0]    r_shift;
   logic          r_samp;
   logic          r_done;
   logic          r_ackErr;
   logic [7:0]    r_rdata;
   logic          w_accept;
   logic          w_tick;
   logic          w_sample;
   logic          w_bitEnd;
   logic          w_lastBit;
   logic          w_rw;

   // Each bit period is four ticks; SDA is sampled on entry to q2 and the
   // state moves on at the q3 tick.
   assign w_accept  = cmd_valid && (r_state == IDLE);
   assign w_tick    = (r_state != IDLE) && (r_qcnt == QMAX);
   assign w_sample  = w_tick && (r_q == 2'd1);
   assign w_bitEnd  = w_tick && (r_q == 2'd3);
   assign w_lastBit = (r_bit == 3'd0);
   assign w_rw      = r_addrByte[0];

   assign busy    = (r_state != IDLE);
   assign done    = r_done;
   assign ack_err = r_ackErr;
   assign rdata   = r_rdata;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   // Next-state logic: every state ends on a bit-period boundary
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:     if (w_accept) w_next = START;
         START:    if (w_bitEnd) w_next = ADDR;
         ADDR:     if (w_bitEnd && w_lastBit) w_next = ADDR_ACK;
         ADDR_ACK: if (w_bitEnd) begin
                      if (r_samp)    w_next = STOP;
                      else if (w_rw) w_next = RDATA;
                      else           w_next = WDATA;
                   end
         WDATA:    if (w_bitEnd && w_lastBit) w_next = DATA_ACK;
         RDATA:    if (w_bitEnd && w_lastBit) w_next = DATA_ACK;
         DATA_ACK: if (w_bitEnd) w_next = STOP;
         STOP:     if (w_bitEnd) w_next = IDLE;
         default:  w_next = IDLE;
      endcase
   end

   // Bus line drive decoded from state, quarter phase and bit index
   always_comb begin
      scl    = 1'b1;
      sda_oe = 1'b0;
      case (r_state)
         START: begin
            scl    = (r_q != 2'd3);
            sda_oe = r_q[1];
         end
         ADDR: begin
            scl    = r_q[1];
            sda_oe = ~r_addrByte[r_bit];
         end
         WDATA: begin
            scl    = r_q[1];
            sda_oe = ~r_wdata[r_bit];
         end
         ADDR_ACK, RDATA, DATA_ACK: begin
            scl    = r_q[1];
            sda_oe = 1'b0;
         end
         STOP: begin
            scl    = (r_q != 2'd0);
            sda_oe = ~r_q[1];
         end
         default: begin
            scl    = 1'b1;
            sda_oe = 1'b0;
         end
      endcase
   end

   // Quarter, phase and bit counters; idle between transactions
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_qcnt <= '0;
         r_q    <= 2'd0;
         r_bit  <= 3'd0;
      end else if (w_accept) begin
         r_qcnt <= '0;
         r_q    <= 2'd0;
         r_bit  <= 3'd7;
      end else if (r_state != IDLE) begin
         if (w_tick) begin
            r_qcnt <= '0;
            r_q    <= r_q + 2'd1;
         end else begin
            r_qcnt <= r_qcnt + QW'(1);
         end
         if (w_bitEnd && ((r_state == ADDR) || (r_state == WDATA) || (r_state == RDATA)))
            r_bit <= w_lastBit ? 3'd7 : (r_bit - 3'd1);
      end
   end

   // Command capture, SDA sampling, ACK error tracking and completion
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addrByte <= 8'h00;
         r_wdata    <= 8'h00;
         r_shift    <= 8'h00;
         r_samp     <= 1'b0;
         r_done     <= 1'b0;
         r_ackErr   <= 1'b0;
         r_rdata    <= 8'h00;
      end else begin
         r_done <= (r_state == STOP) && w_bitEnd;
         if (w_accept) begin
            r_addrByte <= {cmd_addr, cmd_rw};
            r_wdata    <= cmd_wdata;
            r_ackErr   <= 1'b0;
         end
         if (w_sample) begin
            r_samp <= sda_in;
            if (r_state == RDATA) r_shift <= {r_shift[6:0], sda_in};
         end
         if (w_bitEnd && (r_state == ADDR_ACK) && r_samp) r_ackErr <= 1'b1;
         if (w_bitEnd && (r_state == DATA_ACK) && !w_rw && r_samp) r_ackErr <= 1'b1;
         if (w_bitEnd && (r_state == STOP) && w_rw) r_rdata <= r_shift;
      end
   end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: scoreboard bench for i2c_master with a bus-level slave model.
// Stimulus pushes expected bus events and completion results; independent
// monitors pop and compare as the bus and the done pulse occur.
module tb_i2c_master;

   localparam int CLK_DIV  = 2;
   localparam int FULL_LAT = 80 * CLK_DIV;
   localparam int NACK_LAT = 44 * CLK_DIV;
   localparam int EV_START = 256;
   localparam int EV_STOP  = 257;
   localparam int EV_ACK   = 300;

   typedef struct packed {
      logic        ackErr;
      logic [7:0]  rdata;
      logic [15:0] latency;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cmd_valid = 1'b0;
   logic [6:0] cmd_addr = 7'h00;
   logic       cmd_rw = 1'b0;
   logic [7:0] cmd_wdata = 8'h00;
   logic       scl;
   logic       sda_oe;
   logic       busy;
   logic       done;
   logic       ack_err;
   logic [7:0] rdata;
   logic       slaveLow = 1'b0;
   logic       busSda;

   logic       ackAddr = 1'b1;
   logic       ackData = 1'b1;
   logic [7:0] readByte = 8'h00;
   logic [7:0] modelRdata = 8'h00;

   int    expBus[$];
   exp_t  expDone[$];
   string expName[$];
   int    acceptQ[$];
   int    checks = 0;
   int    errors = 0;
   int    cycleCount = 0;

   assign busSda = ~(sda_oe | slaveLow);

   i2c_master #(.CLK_DIV(CLK_DIV)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_addr  (cmd_addr),
      .cmd_rw    (cmd_rw),
      .cmd_wdata (cmd_wdata),
      .sda_in    (busSda),
      .scl       (scl),
      .sda_oe    (sda_oe),
      .busy      (busy),
      .done      (done),
      .ack_err   (ack_err),
      .rdata     (rdata)
   );

   // Free-running clock and cycle counter used for latency measurement
   always #5 clk = ~clk;

   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic busEvent(input int ev);
      if (expBus.size() == 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL busEvent: got %0d, expected no event", ev);
      end else begin
         checkOutput("busEvent", ev, expBus.pop_front());
      end
   endtask

   // Queue the bus trace and completion result a transaction should produce
   task automatic expectTxn(input string name, input logic [6:0] addr, input logic rw,
                            input logic [7:0] data, input logic aAck, input logic dAck);
      exp_t e;
      expBus.push_back(EV_START);
      expBus.push_back(int'({addr, rw}));
      expBus.push_back(aAck ? EV_ACK : EV_ACK + 1);
      if (aAck) begin
         expBus.push_back(int'(data));
         expBus.push_back((rw || !dAck) ? EV_ACK + 1 : EV_ACK);
      end
      expBus.push_back(EV_STOP);
      if (aAck && rw) modelRdata = data;
      e.ackErr  = !aAck || (!rw && !dAck);
      e.rdata   = modelRdata;
      e.latency = aAck ? 16'(FULL_LAT) : 16'(NACK_LAT);
      expDone.push_back(e);
      expName.push_back(name);
   endtask

   task automatic applyStimulus(input logic [6:0] addr, input logic rw, input logic [7:0] wdata);
      cmd_valid = 1'b1;
      cmd_addr  = addr;
      cmd_rw    = rw;
      cmd_wdata = wdata;
      @(posedge clk);
      #1;
      acceptQ.push_back(cycleCount);
      cmd_valid = 1'b0;
   endtask

   task automatic waitDone(input string name, input int budget);
      int n;
      n = 0;
      @(negedge clk);
      while (!done && n < budget) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("[TB] FAIL %s.timeout: done not seen within %0d cycles", name, budget);
      end
   endtask

   // Bus monitor and slave model: decodes START/STOP, bytes and ACK bits,
   // and drives ACKs and read data while SCL is low
   logic prevScl = 1'b1;
   logic prevSda = 1'b1;
   logic sclNow;
   logic sdaNow;
   int   bitCnt = 0;
   int   byteNum = 0;
   logic [7:0] curByte = 8'h00;
   logic isRead = 1'b0;

   always @(negedge clk) begin
      if (rst) begin
         prevScl  = 1'b1;
         prevSda  = 1'b1;
         bitCnt   = 0;
         byteNum  = 0;
         slaveLow = 1'b0;
      end else begin
         sclNow = scl;
         sdaNow = busSda;
         if (prevScl && sclNow && prevSda && !sdaNow) begin
            busEvent(EV_START);
            bitCnt   = 0;
            byteNum  = 0;
            slaveLow = 1'b0;
         end else if (prevScl && sclNow && !prevSda && sdaNow) begin
            busEvent(EV_STOP);
            slaveLow = 1'b0;
         end else if (!prevScl && sclNow) begin
            if (bitCnt < 8) curByte = {curByte[6:0], sdaNow};
            else if (bitCnt == 8) busEvent(sdaNow ? EV_ACK + 1 : EV_ACK);
            bitCnt++;
         end else if (prevScl && !sclNow) begin
            if (bitCnt == 9) begin
               bitCnt = 0;
               byteNum++;
            end
            if (bitCnt == 8) begin
               busEvent(int'(curByte));
               if (byteNum == 0) begin
                  isRead   = curByte[0];
                  slaveLow = ackAddr;
               end else if (byteNum == 1 && !isRead) begin
                  slaveLow = ackData;
               end else begin
                  slaveLow = 1'b0;
               end
            end else if (byteNum == 1 && isRead && ackAddr && bitCnt < 8) begin
               slaveLow = ~readByte[7 - bitCnt];
            end else begin
               slaveLow = 1'b0;
            end
         end
         prevScl = sclNow;
         prevSda = sdaNow;
      end
   end

   // Completion monitor: compares each done pulse with the queued result
   logic prevDone = 1'b0;
   exp_t curExp;
   string curName;
   int   lat;

   always @(negedge clk) begin
      if (!rst && done) begin
         checkOutput("donePulse", int'(prevDone), 0);
         if (expDone.size() == 0 || acceptQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedDone: got done=1, expected no completion");
         end else begin
            curExp  = expDone.pop_front();
            curName = expName.pop_front();
            lat     = cycleCount - acceptQ.pop_front();
            checkOutput({curName, ".latency"}, lat, int'(curExp.latency));
            checkOutput({curName, ".ackErr"}, int'(ack_err), int'(curExp.ackErr));
            checkOutput({curName, ".rdata"}, int'(rdata), int'(curExp.rdata));
            checkOutput({curName, ".busy"}, int'(busy), 0);
         end
      end
      prevDone = done;
   end

   // Directed transaction sequence
   initial begin
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      checkOutput("reset.scl", int'(scl), 1);
      checkOutput("reset.sdaOe", int'(sda_oe), 0);
      checkOutput("reset.busy", int'(busy), 0);
      checkOutput("reset.done", int'(done), 0);
      checkOutput("reset.ackErr", int'(ack_err), 0);
      checkOutput("reset.rdata", int'(rdata), 0);
      rst = 1'b0;
      @(negedge clk);

      // Write with a stray command mid-transaction that must be ignored
      ackAddr = 1'b1;
      ackData = 1'b1;
      expectTxn("write", 7'h2A, 1'b0, 8'hC3, 1'b1, 1'b1);
      applyStimulus(7'h2A, 1'b0, 8'hC3);
      repeat (40) @(negedge clk);
      checkOutput("busyMid", int'(busy), 1);
      cmd_valid = 1'b1;
      cmd_addr  = 7'h7F;
      cmd_rw    = 1'b1;
      cmd_wdata = 8'hFF;
      @(negedge clk);
      cmd_valid = 1'b0;
      waitDone("write", 200);

      // Read: slave returns 0xA5, master NACKs the data byte
      @(negedge clk);
      readByte = 8'hA5;
      expectTxn("read", 7'h15, 1'b1, 8'hA5, 1'b1, 1'b1);
      applyStimulus(7'h15, 1'b1, 8'h00);
      waitDone("read", 200);

      // Address NACK: no data byte, short transaction
      @(negedge clk);
      ackAddr = 1'b0;
      expectTxn("addrNack", 7'h33, 1'b0, 8'h55, 1'b0, 1'b1);
      applyStimulus(7'h33, 1'b0, 8'h55);
      waitDone("addrNack", 200);
      @(negedge clk);
      checkOutput("ackErrHeld", int'(ack_err), 1);
      checkOutput("rdataHeld", int'(rdata), 8'hA5);

      // Write-data NACK followed by a command issued in the done cycle
      ackAddr = 1'b1;
      ackData = 1'b0;
      expectTxn("dataNack", 7'h2A, 1'b0, 8'h00, 1'b1, 1'b0);
      applyStimulus(7'h2A, 1'b0, 8'h00);
      waitDone("dataNack", 200);
      expectTxn("backToBack", 7'h2A, 1'b0, 8'hC3, 1'b1, 1'b1);
      ackData = 1'b1;
      applyStimulus(7'h2A, 1'b0, 8'hC3);
      checkOutput("ackErrCleared", int'(ack_err), 0);
      waitDone("backToBack", 200);

      // Asynchronous reset in the middle of the address byte
      @(negedge clk);
      expBus.push_back(EV_START);
      applyStimulus(7'h2A, 1'b0, 8'hC3);
      void'(acceptQ.pop_back());
      repeat (20) @(posedge clk);
      #3 rst = 1'b1;
      modelRdata = 8'h00;
      #1;
      checkOutput("rstMid.scl", int'(scl), 1);
      checkOutput("rstMid.sdaOe", int'(sda_oe), 0);
      checkOutput("rstMid.busy", int'(busy), 0);
      checkOutput("rstMid.busTrace", expBus.size(), 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      expectTxn("afterReset", 7'h2A, 1'b0, 8'hC3, 1'b1, 1'b1);
      applyStimulus(7'h2A, 1'b0, 8'hC3);
      waitDone("afterReset", 200);

      @(negedge clk);
      checkOutput("busLeftover", expBus.size(), 0);
      checkOutput("doneLeftover", expDone.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
